note_sequencer: RTL

Song sequencer directly upstream of the musicbox tone generator. Walks a song ROM event by event, each event a pitch plus a duration in beat ticks. Holds the current pitch on `fullnote` for exactly that many ticks, then fetches the next event. Handles pause, song select, restart and end-of-song, and replaces the free-running-counter ROM addressing with explicit, tempo-accurate note timing.

---
 rtl/musicbox_pkg.sv | 20 ++
 rtl/note_sequencer_beat_tick.sv | 31 +++
 rtl/note_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/musicbox_pkg.sv
// Shared types and ROM word layout for the musicbox song sequencer.
package musicbox_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_PLAY,
        ST_DONE
    } seq_state_t;

    localparam int PITCH_MSB = 9;
    localparam int PITCH_LSB = 4;
    localparam int DUR_MSB   = 3;
    localparam int DUR_LSB   = 0;

    localparam logic [3:0] END_MARKER = 4'd0;
    localparam logic [5:0] REST_PITCH = 6'd0;

endpackage

// File: rtl/note_sequencer_beat_tick.sv
// beat_tick: divides clk by TICK_DIV while enabled, pulsing o_tick on the wrap cycle.
module beat_tick #(
    parameter int TICK_DIV = 6_250_000
) (
    input  logic clk,
    input  logic RESET,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_tick = i_en && w_wrap;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Song sequencer: walks an external song ROM, holding each pitch for its duration in beat ticks.
// Optional NOTE_GAP_EN silences the final tick of events lasting two or more ticks.
module note_sequencer
    import musicbox_pkg::*;
#(
    parameter int TICK_DIV = 6_250_000,
    parameter int ADDR_W   = 9,
    parameter int LOOP     = 0
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic            pause,
    input  logic            song_sel,
    input  logic            restart,
    output logic [ADDR_W:0] rom_addr,
    input  logic [9:0]      rom_data,
    output logic [10:0]     fullnote,
    output logic            note_strobe,
    output logic            playing,
    output logic            song_done
);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [3:0]        r_remaining;
    logic              r_sel;
    logic [ADDR_W:0]   r_rom_addr;
    logic [10:0]       r_fullnote;
    logic              r_strobe;
    logic              r_playing;
    logic              r_done;

    logic       w_reload;
    logic       w_tick;
    logic [3:0] w_dur;
    logic [5:0] w_pitch;

    assign w_reload = restart || (song_sel != r_sel);
    assign w_dur    = rom_data[DUR_MSB:DUR_LSB];
    assign w_pitch  = rom_data[PITCH_MSB:PITCH_LSB];

    beat_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_beat_tick (
        .clk   (clk),
        .RESET (RESET),
        .i_en  ((r_state == ST_PLAY) && !pause && !w_reload),
        .i_clr ((r_state == ST_LOAD) && !pause),
        .o_tick(w_tick)
    );

    // Reload outranks pause so a frozen sequencer can still be retargeted.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_FETCH;
            r_idx       <= '0;
            r_remaining <= '0;
            r_sel       <= song_sel;
            r_rom_addr  <= '0;
            r_fullnote  <= '0;
            r_strobe    <= 1'b0;
            r_playing   <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_reload) begin
            r_state    <= ST_FETCH;
            r_idx      <= '0;
            r_sel      <= song_sel;
            r_fullnote <= '0;
            r_done     <= 1'b0;
            r_strobe   <= 1'b0;
            r_playing  <= 1'b0;
        end else if (pause) begin
            r_strobe  <= 1'b0;
            r_playing <= 1'b0;
        end else begin
            r_strobe  <= 1'b0;
            r_playing <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    r_rom_addr <= {r_sel, r_idx};
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_dur != END_MARKER) begin
                        r_fullnote  <= {5'b0, w_pitch};
                        r_remaining <= w_dur;
                        r_strobe    <= 1'b1;
                        r_playing   <= 1'b1;
                        r_state     <= ST_PLAY;
                    end else if (LOOP != 0) begin
                        r_idx   <= '0;
                        r_state <= ST_FETCH;
                    end else begin
                        r_fullnote <= '0;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_PLAY: begin
                    r_playing <= 1'b1;
                    if (w_tick) begin
                        if (r_remaining == 4'd1) begin
                            r_idx     <= r_idx + 1'b1;
                            r_playing <= 1'b0;
                            r_state   <= ST_FETCH;
                        end else begin
                            r_remaining <= r_remaining - 1'b1;
`ifdef NOTE_GAP_EN
                            if (r_remaining == 4'd2) begin
                                r_fullnote <= '0;
                            end
`endif
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign rom_addr    = r_rom_addr;
    assign fullnote    = r_fullnote;
    assign note_strobe = r_strobe;
    assign playing     = r_playing;
    assign song_done   = r_done;

endmodule
